// File: rtl/sprite_line_engine.sv
// sprite_line_engine: multi-sprite scanline compositor into a ping-pong line buffer.
// Optional horizontal mirroring via attr bit 27 when SPRITE_FLIP_EN is defined.
module sprite_line_engine #(
    parameter int NUM_SPRITES = 8,
    parameter int LB_DEPTH    = 320,
    parameter int IDX_W       = (NUM_SPRITES > 1) ? $clog2(NUM_SPRITES) : 1
) (
    input  logic             i_Clk,
    input  logic             reset,
    input  logic             attr_write,
    input  logic [IDX_W-1:0] attr_index,
    input  logic [27:0]      attr_wr_data,
    input  logic             line_start,
    input  logic [9:0]       next_row,
    input  logic             rd_en,
    input  logic [9:0]       rd_x,
    output logic [1:0]       rd_pixel,
    output logic [5:0]       rom_sprite_num,
    output logic [2:0]       rom_row,
    output logic [2:0]       rom_col,
    input  logic [1:0]       rom_pixel,
    output logic             busy,
    output logic             overflow
);
    localparam int AW = (LB_DEPTH > 1) ? $clog2(LB_DEPTH) : 1;
    localparam logic [9:0] DEPTH = 10'(LB_DEPTH);
    localparam logic [AW-1:0] LAST = AW'(LB_DEPTH - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPRITES - 1);

    typedef enum logic [2:0] {CLEAR, IDLE, SCAN, FETCH, DRAIN} state_t;

    state_t           state;
    logic [27:0]      attr [NUM_SPRITES];
    logic [1:0]       lb [2][LB_DEPTH];
    logic             front;
    logic [9:0]       row;
    logic [IDX_W-1:0] idx;
    logic [2:0]       c;
    logic [8:0]       x_l;
    logic [AW-1:0]    cnt;
    logic             pend;
    logic [9:0]       pend_addr;
`ifdef SPRITE_FLIP_EN
    logic             flip;
`endif

    logic [27:0] cur;
    logic [9:0]  dy;
    logic [9:0]  ra;
    logic        hit;
    logic        rd_ok;
    logic        wr_ok;
    logic [2:0]  col;

    always_comb begin
        cur   = attr[idx];
        dy    = row - cur[19:10];
        hit   = cur[26] && dy[9:4] == 6'd0;
        ra    = {1'b0, rd_x[9:1]};
        rd_ok = ra < DEPTH;
        wr_ok = pend && rom_pixel != 2'd0 && pend_addr < DEPTH;
`ifdef SPRITE_FLIP_EN
        col   = flip ? ~c : c;
`else
        col   = c;
`endif
    end

    logic unused_bits;
`ifdef SPRITE_FLIP_EN
    assign unused_bits = ^{rd_x[0], cur[0], dy[0]};
`else
    assign unused_bits = ^{rd_x[0], cur[27], cur[0], dy[0]};
`endif

    // The display read clears the front bank; the render writes the back bank.
    always_ff @(posedge i_Clk) begin
        if (state == CLEAR) begin
            lb[0][cnt] <= 2'd0;
            lb[1][cnt] <= 2'd0;
        end
        if (rd_en && rd_ok) lb[front][ra[AW-1:0]] <= 2'd0;
        if (wr_ok) lb[~front][pend_addr[AW-1:0]] <= rom_pixel;
    end

    always_ff @(posedge i_Clk) begin
        if (reset) begin
            state          <= CLEAR;
            cnt            <= '0;
            busy           <= 1'b1;
            overflow       <= 1'b0;
            front          <= 1'b0;
            rd_pixel       <= 2'd0;
            rom_sprite_num <= 6'd0;
            rom_row        <= 3'd0;
            rom_col        <= 3'd0;
            pend           <= 1'b0;
            pend_addr      <= 10'd0;
            idx            <= '0;
            c              <= 3'd0;
            row            <= 10'd0;
            x_l            <= 9'd0;
`ifdef SPRITE_FLIP_EN
            flip           <= 1'b0;
`endif
            for (int k = 0; k < NUM_SPRITES; k++) attr[k] <= 28'd0;
        end else begin
            if (attr_write && attr_index <= LAST_IDX) attr[attr_index] <= attr_wr_data;
            // Bank contents are undefined until the clear sweep has finished.
            if (rd_en) rd_pixel <= (state == CLEAR || !rd_ok) ? 2'd0 : lb[front][ra[AW-1:0]];
            pend <= 1'b0;
            if (state != CLEAR && line_start) begin
                overflow <= overflow | (state != IDLE);
                row      <= next_row;
                front    <= ~front;
                idx      <= LAST_IDX;
                state    <= SCAN;
                busy     <= 1'b1;
            end else begin
                case (state)
                    CLEAR: begin
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end
                    IDLE: ;
                    SCAN: begin
                        if (hit) begin
                            rom_sprite_num <= cur[25:20];
                            rom_row        <= dy[3:1];
                            x_l            <= cur[9:1];
`ifdef SPRITE_FLIP_EN
                            flip           <= cur[27];
`endif
                            c              <= 3'd0;
                            state          <= FETCH;
                        end else if (idx == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx <= idx - 1'b1;
                        end
                    end
                    FETCH: begin
                        rom_col   <= col;
                        c         <= c + 3'd1;
                        pend      <= 1'b1;
                        pend_addr <= {1'b0, x_l} + {7'd0, c};
                        if (c == 3'd7) state <= DRAIN;
                    end
                    DRAIN: begin
                        if (idx == '0) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else begin
                            idx   <= idx - 1'b1;
                            state <= SCAN;
                        end
                    end
                    default: state <= CLEAR;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_sprite_line_engine.sv
// tb_sprite_line_engine: directed and randomized line renders checked against a line model.
module tb_sprite_line_engine;
    localparam int N = 8;
    localparam int D = 320;

    logic        i_Clk = 1'b0;
    logic        reset = 1'b1;
    logic        attr_write = 1'b0;
    logic [2:0]  attr_index = 3'd0;
    logic [27:0] attr_wr_data = 28'd0;
    logic        line_start = 1'b0;
    logic [9:0]  next_row = 10'd0;
    logic        rd_en = 1'b0;
    logic [9:0]  rd_x = 10'd0;
    logic [1:0]  rd_pixel;
    logic [5:0]  rom_sprite_num;
    logic [2:0]  rom_row;
    logic [2:0]  rom_col;
    logic [1:0]  rom_pixel;
    logic        busy;
    logic        overflow;

    sprite_line_engine #(.NUM_SPRITES(N), .LB_DEPTH(D)) dut (
        .i_Clk(i_Clk), .reset(reset), .attr_write(attr_write), .attr_index(attr_index),
        .attr_wr_data(attr_wr_data), .line_start(line_start), .next_row(next_row),
        .rd_en(rd_en), .rd_x(rd_x), .rd_pixel(rd_pixel), .rom_sprite_num(rom_sprite_num),
        .rom_row(rom_row), .rom_col(rom_col), .rom_pixel(rom_pixel), .busy(busy),
        .overflow(overflow)
    );

    always #5 i_Clk = ~i_Clk;

    logic [1:0]  rom_mem [4096];
    assign rom_pixel = rom_mem[{rom_sprite_num, rom_row, rom_col}];

    logic [27:0] sh [N];
    int exp_prev [D];
    int exp_new [D];
    int hits;
    int last_r;
    int checks = 0;
    int errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic wr_attr(input int s, input int fl, input int en, input int num, input int y, input int x);
        attr_write   = 1'b1;
        attr_index   = s[2:0];
        attr_wr_data = {fl[0], en[0], num[5:0], y[9:0], x[9:0]};
        sh[s]        = attr_wr_data;
        tick();
        attr_write   = 1'b0;
    endtask

    // Paint sprites lowest priority first so higher-priority sprites land on top.
    task automatic model(input int row);
        for (int e = 0; e < D; e++) exp_new[e] = 0;
        hits = 0;
        for (int s = N - 1; s >= 0; s--) begin
            int dy, r, cl, p, e;
            if (sh[s][26]) begin
                dy = (row - int'(sh[s][19:10]) + 1024) % 1024;
                if (dy < 16) begin
                    hits++;
                    r = dy / 2;
                    last_r = r;
                    for (int k = 0; k < 8; k++) begin
                        cl = k;
`ifdef SPRITE_FLIP_EN
                        if (sh[s][27]) cl = 7 - k;
`endif
                        p = int'(rom_mem[int'(sh[s][25:20]) * 64 + r * 8 + cl]);
                        e = int'(sh[s][9:0]) / 2 + k;
                        if (p != 0 && e < D) exp_new[e] = p;
                    end
                end
            end
        end
    endtask

    task automatic pulse(input int row);
        model(row);
        next_row   = row[9:0];
        line_start = 1'b1;
        tick();
        line_start = 1'b0;
    endtask

    task automatic wait_render(input string tag, input int expk);
        int n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            tick();
        end
        check(tag, n, expk);
    endtask

    task automatic read_front(input bit chk);
        for (int e = 0; e < D; e++) begin
            rd_en = 1'b1;
            rd_x  = 10'(2 * e + int'($urandom_range(0, 1)));
            tick();
            if (chk) check($sformatf("pix%0d", e), rd_pixel, exp_prev[e]);
        end
        rd_en = 1'b0;
        rd_x  = 10'($urandom_range(0, 639));
        tick();
        if (chk) check("hold", rd_pixel, exp_prev[D - 1]);
    endtask

    task automatic copy_exp();
        for (int e = 0; e < D; e++) exp_prev[e] = exp_new[e];
    endtask

    task automatic line(input int row, input string tag);
        pulse(row);
        wait_render(tag, N + 9 * hits);
        if (hits > 0) check({tag, "_row"}, rom_row, last_r);
        read_front(1'b1);
        copy_exp();
    endtask

    task automatic disable_all();
        for (int s = 0; s < N; s++) wr_attr(s, 0, 0, 0, 0, 0);
    endtask

    initial begin
        int bc, row, y;
        for (int i = 0; i < 4096; i++) rom_mem[i] = ($urandom % 3 == 0) ? 2'd0 : 2'($urandom_range(1, 3));
        for (int s = 0; s < N; s++) sh[s] = 28'd0;
        for (int e = 0; e < D; e++) exp_prev[e] = 0;

        repeat (3) tick();
        check("rst_busy", busy, 1);
        check("rst_ovf", overflow, 0);
        check("rst_pix", rd_pixel, 0);
        check("rst_num", rom_sprite_num, 0);
        check("rst_row", rom_row, 0);
        check("rst_col", rom_col, 0);
        reset = 1'b0;
        bc = busy ? 1 : 0;
        for (int x = 0; x < 640; x++) begin
            rd_en = 1'b1;
            rd_x  = 10'(x);
            tick();
            check("clr_pix", rd_pixel, 0);
            if (busy) bc++;
        end
        rd_en = 1'b0;
        check("clr_busy", bc, D);
        check("idle_busy", busy, 0);

        wr_attr(0, 0, 1, 3, 100, 200);
        line(101, "single");
        wr_attr(1, 0, 1, 5, 100, 200);
        line(105, "overlap");
        wr_attr(1, 0, 0, 0, 0, 0);
        wr_attr(0, 0, 1, 7, 50, 636);
        line(60, "edge");
        wr_attr(0, 1, 1, 9, 1020, 40);
        line(3, "wrap_flip");

        repeat (6) begin
            row = int'($urandom_range(0, 1023));
            for (int s = 0; s < N; s++) begin
                y = (row - int'($urandom_range(0, 24)) + 1024) % 1024;
                wr_attr(s, int'($urandom_range(0, 1)), ($urandom % 4 != 0) ? 1 : 0,
                        int'($urandom_range(0, 63)), y, int'($urandom_range(0, 700)));
            end
            line(row, "rand");
        end
        disable_all();
        line(200, "flush");

        for (int s = 0; s < N; s++) wr_attr(s, 0, 1, s * 5, 300, s * 70);
        pulse(305);
        repeat (40) tick();
        check("ovf_pre", overflow, 0);
        pulse(310);
        check("ovf_set", overflow, 1);
        wait_render("ovf_render", N + 9 * hits);
        read_front(1'b0);
        copy_exp();
        disable_all();
        line(10, "after_ovf");
        check("ovf_sticky", overflow, 1);

        wr_attr(2, 0, 1, 11, 500, 100);
        pulse(505);
        repeat (5) tick();
        reset = 1'b1;
        tick();
        check("mid_rst_busy", busy, 1);
        check("mid_rst_ovf", overflow, 0);
        check("mid_rst_pix", rd_pixel, 0);
        reset = 1'b0;
        for (int s = 0; s < N; s++) sh[s] = 28'd0;
        for (int e = 0; e < D; e++) exp_prev[e] = 0;
        wait_render("reclear", D);
        line(505, "attr_cleared");
        line(505, "empty");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
